exc_ctrl: RTL
=============

Name: exc_ctrl

Overview:
- Exception arbitration and redirect stage between the MEM stage and cp0.
- Collects per-instruction exception flags from MEM and merges the pending-interrupt line from cp0.
- Picks one exception type by priority and drives cp0's exception inputs (flag, type, pc, baddr, inslot).
- Kills the offending memory access, flushes the pipeline, and holds a redirect PC (vector or EPC) until fetch accepts it.

Parameters:
- VEC_BEV1, 32'hBFC00380, exception vector when Status.BEV=1
- VEC_BEV0, 32'h80000180, exception vector when Status.BEV=0

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- mem_valid_i  in  1  MEM holds a real instruction this cycle
- mem_pc_i  in  32  PC of the MEM instruction
- mem_inslot_i  in  1  MEM instruction is in a delay slot
- mem_addr_i  in  32  load/store effective address
- mem_exc_i  in  8  {ades, adel_ld, eret, ri, ov, sysc, bp, adel_if}, bit 0 = adel_if
- exc_intr_i  in  1  cp0 interrupt request (cp0's exc_intr)
- status_i  in  32  cp0 Status (bit 22 BEV, bit 1 EXL)
- epc_i  in  32  cp0 EPC
- redirect_ready_i  in  1  fetch accepts the redirect this cycle
- cp0_exc_flag_o  out  1  exception taken this cycle (to cp0_exc_flag_i)
- cp0_exc_type_o  out  `ExcT  selected type
- cp0_pc_o  out  32  = mem_pc_i
- cp0_baddr_o  out  32  bad address
- cp0_inslot_o  out  1  = mem_inslot_i
- mem_cancel_o  out  1  suppress the MEM store/load side effects this cycle
- flush_o  out  1  kill IF..MEM
- redirect_valid_o  out  1  redirect PC valid
- redirect_pc_o  out  32  target PC

Behaviour:
- FSM states: IDLE, REDIRECT. Reset puts the FSM in IDLE; all outputs are 0.
- take = state==IDLE & mem_valid_i & (exc_intr_i | mem_exc_i != 0). Combinational, same cycle.
- While state==REDIRECT, inputs are ignored.
- Priority, highest first:
  - Intr
  - AdEL1 (adel_if)
  - RI
  - Ov / SysC / Bp / ERET; decode makes these mutually exclusive, and if several are set anyway the order is Ov > SysC > Bp > ERET
  - AdEL2 (adel_ld)
  - AdES
- cp0_exc_flag_o = take; cp0_exc_type_o = selected type, or ExcT_None when take=0.
- cp0_baddr_o:
  - AdEL1: mem_pc_i
  - AdEL2 / AdES: mem_addr_i
  - all other types: 0
- mem_cancel_o = take, for every type including ERET and Intr; the MEM instruction does not commit.
- flush_o = take | (state==REDIRECT).
- Redirect target is computed in cycle T from pre-update cp0 values:
  - ERET: epc_i
  - otherwise: status_i[22] ? VEC_BEV1 : VEC_BEV0
  - The target is registered at the posedge ending T.
- Transitions:
  - IDLE -> REDIRECT on take.
  - REDIRECT -> IDLE on redirect_ready_i.
  - redirect_valid_o = (state==REDIRECT).
  - redirect_pc_o holds stable until the handshake completes.
- Interrupt with no valid instruction in MEM: not taken. It is taken on the first cycle with mem_valid_i=1 and exc_intr_i still high, and attaches to that PC.
- EXL=1 is not masked here: cp0 decides whether EPC updates. A nested non-interrupt exception still redirects to the vector.
- redirect_ready_i in the first REDIRECT cycle: single-cycle redirect, IDLE next cycle. A new take is possible the cycle after that.
- redirect_ready_i while in IDLE is ignored.
- rst asserted in REDIRECT: IDLE next cycle, redirect_valid_o=0, redirect_pc_o=0.

Decomposition:
- Shared package / defines.v holds:
  - `ExcT width and codes: None, Intr, AdEL1, AdEL2, AdES, Ov, SysC, Bp, RI, ERET.
  - Status bit indices BEV/EXL.
  - The two vector constants.
- One natural sub-module, exc_prio_enc: combinational priority encoder from {exc_intr, mem_exc} to `ExcT plus a baddr select.
- The FSM and redirect register live in exc_ctrl.

Test Plan:
- Reset, then mem_valid=1, ri set, pc=0xBFC00010, BEV=1 -> same cycle: flag=1, type=RI, mem_cancel=1, flush=1; next cycle: redirect_valid=1, pc=0xBFC00380; held 3 cycles until ready=1, IDLE after.
- Load with adel_ld, addr=0x80000003, pc=0x80001000, inslot=1, BEV=0 -> type=AdEL2, baddr=0x80000003, inslot=1; redirect pc=0x80000180.
- ERET with epc_i=0x80002004 -> type=ERET; redirect pc=0x80002004; ready in the first REDIRECT cycle gives one redirect cycle only.
- exc_intr=1 while mem_valid=0 for 4 cycles -> no take; then mem_valid=1 with ov set, pc=0x80000040 -> type=Intr (beats Ov), cp0_pc=0x80000040.
- In REDIRECT, mem_valid=1 with sysc -> ignored (flag=0, flush=1); rst pulse mid-REDIRECT -> redirect_valid=0 next cycle.
- adel_if and adel_ld both set, pc=0x80000101 -> type=AdEL1, baddr=0x80000101.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exc_ctrl_pkg
//  Description : Shared exception type codes, Status bit indices, mem_exc bit
//                positions and exception vectors for the exception stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package exc_ctrl_pkg;

    // Exception type delivered to cp0
    typedef enum logic [3:0] {
        EXC_NONE  = 4'd0,
        EXC_INTR  = 4'd1,
        EXC_ADEL1 = 4'd2,
        EXC_ADEL2 = 4'd3,
        EXC_ADES  = 4'd4,
        EXC_OV    = 4'd5,
        EXC_SYSC  = 4'd6,
        EXC_BP    = 4'd7,
        EXC_RI    = 4'd8,
        EXC_ERET  = 4'd9
    } exc_t;

    // Source of the bad-address value
    typedef enum logic [1:0] {
        BADDR_ZERO = 2'd0,
        BADDR_PC   = 2'd1,
        BADDR_ADDR = 2'd2
    } baddr_sel_t;

    // Redirect FSM
    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_t;

    // Status register bit indices
    localparam int C_STATUS_BEV = 22;
    localparam int C_STATUS_EXL = 1;

    // mem_exc bit positions
    localparam int C_MEXC_ADEL_IF = 0;
    localparam int C_MEXC_BP      = 1;
    localparam int C_MEXC_SYSC    = 2;
    localparam int C_MEXC_OV      = 3;
    localparam int C_MEXC_RI      = 4;
    localparam int C_MEXC_ERET    = 5;
    localparam int C_MEXC_ADEL_LD = 6;
    localparam int C_MEXC_ADES    = 7;

    // Exception vectors
    localparam logic [31:0] C_VEC_BEV1 = 32'hBFC0_0380;
    localparam logic [31:0] C_VEC_BEV0 = 32'h8000_0180;

endpackage : exc_ctrl_pkg
`default_nettype wire

// File: rtl/exc_ctrl_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : exc_ctrl_prio_enc
//  Description : Priority encoder from {interrupt, MEM exception flags} to a
//                single exception type plus the bad-address source select.
//  Revision    : 1.0 - initial release
// ============================================================================
module exc_ctrl_prio_enc
    import exc_ctrl_pkg::*;
(
    input  logic       exc_intr,
    input  logic [7:0] mem_exc,
    output exc_t       exc_type,
    output baddr_sel_t baddr_sel
);

    // Fixed priority: Intr > AdEL1 > RI > Ov > SysC > Bp > ERET > AdEL2 > AdES
    always_comb begin
        exc_type  = EXC_NONE;
        baddr_sel = BADDR_ZERO;
        if (exc_intr) begin
            exc_type  = EXC_INTR;
        end else if (mem_exc[C_MEXC_ADEL_IF]) begin
            exc_type  = EXC_ADEL1;
            baddr_sel = BADDR_PC;
        end else if (mem_exc[C_MEXC_RI]) begin
            exc_type  = EXC_RI;
        end else if (mem_exc[C_MEXC_OV]) begin
            exc_type  = EXC_OV;
        end else if (mem_exc[C_MEXC_SYSC]) begin
            exc_type  = EXC_SYSC;
        end else if (mem_exc[C_MEXC_BP]) begin
            exc_type  = EXC_BP;
        end else if (mem_exc[C_MEXC_ERET]) begin
            exc_type  = EXC_ERET;
        end else if (mem_exc[C_MEXC_ADEL_LD]) begin
            exc_type  = EXC_ADEL2;
            baddr_sel = BADDR_ADDR;
        end else if (mem_exc[C_MEXC_ADES]) begin
            exc_type  = EXC_ADES;
            baddr_sel = BADDR_ADDR;
        end
    end

endmodule : exc_ctrl_prio_enc
`default_nettype wire

// File: rtl/exc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : exc_ctrl
//  Description : Exception arbitration and redirect stage between MEM and cp0.
//                Selects one exception, drives cp0, kills the MEM access,
//                flushes the pipe and holds the redirect PC until fetch
//                accepts it.
//  Revision    : 1.0 - initial release
// ============================================================================
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter logic [31:0] VEC_BEV1 = C_VEC_BEV1,
    parameter logic [31:0] VEC_BEV0 = C_VEC_BEV0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_inslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic [7:0]  mem_exc_i,
    input  logic        exc_intr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] epc_i,
    input  logic        redirect_ready_i,
    output logic        cp0_exc_flag_o,
    output exc_t        cp0_exc_type_o,
    output logic [31:0] cp0_pc_o,
    output logic [31:0] cp0_baddr_o,
    output logic        cp0_inslot_o,
    output logic        mem_cancel_o,
    output logic        flush_o,
    output logic        redirect_valid_o,
    output logic [31:0] redirect_pc_o
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_redirect_pc;
    logic        w_take;
    exc_t        w_type;
    baddr_sel_t  w_baddr_sel;
    logic [31:0] w_target;

    // EXL and the remaining Status bits are cp0's business, not this stage's
    logic        w_unused_status;
    assign w_unused_status = ^{status_i[31:C_STATUS_BEV+1], status_i[C_STATUS_BEV-1:0]};

    exc_ctrl_prio_enc u_prio_enc (
        .exc_intr  (exc_intr_i),
        .mem_exc   (mem_exc_i),
        .exc_type  (w_type),
        .baddr_sel (w_baddr_sel)
    );

    // An exception is taken only from IDLE and only against a real instruction
    assign w_take = (r_state == ST_IDLE) & mem_valid_i & (exc_intr_i | (|mem_exc_i));

    // ERET returns to EPC; everything else goes to the BEV-selected vector
    assign w_target = (w_type == EXC_ERET) ? epc_i
                    : (status_i[C_STATUS_BEV] ? VEC_BEV1 : VEC_BEV0);

    assign cp0_exc_flag_o   = w_take;
    assign cp0_exc_type_o   = w_take ? w_type : EXC_NONE;
    assign cp0_pc_o         = mem_pc_i;
    assign cp0_inslot_o     = mem_inslot_i;
    assign mem_cancel_o     = w_take;
    assign flush_o          = w_take | (r_state == ST_REDIRECT);
    assign redirect_valid_o = (r_state == ST_REDIRECT);
    assign redirect_pc_o    = r_redirect_pc;

    // Bad address mux, zero when nothing is taken
    always_comb begin
        cp0_baddr_o = 32'h0;
        if (w_take) begin
            case (w_baddr_sel)
                BADDR_PC:   cp0_baddr_o = mem_pc_i;
                BADDR_ADDR: cp0_baddr_o = mem_addr_i;
                default:    cp0_baddr_o = 32'h0;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (w_take)           w_state_nxt = ST_REDIRECT;
            ST_REDIRECT: if (redirect_ready_i) w_state_nxt = ST_IDLE;
            default:                           w_state_nxt = ST_IDLE;
        endcase
    end

    // Redirect target: captured on take, held through REDIRECT, cleared on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_redirect_pc <= 32'h0;
        end else if (w_take) begin
            r_redirect_pc <= w_target;
        end else if ((r_state == ST_REDIRECT) && redirect_ready_i) begin
            r_redirect_pc <= 32'h0;
        end
    end

endmodule : exc_ctrl
`default_nettype wire
